// File: rtl/ibus_mem_model.sv
// Instruction-bus memory model: serves 64-bit instruction pairs from a
// word-addressed backing array. Latency and periodic stall are set by parameters.
module ibus_mem_model #(
  parameter int MEM_WORDS    = 65536,
  parameter int LATENCY      = 1,
  parameter int STALL_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic [31:0] address,
  input  logic        flush,
  output logic        stall,
  output logic        valid,
  output logic [63:0] rddata
);

  localparam int              AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(MEM_WORDS - 1);
  localparam logic [31:0]     SP_LAST  = (STALL_PERIOD > 0) ? 32'(STALL_PERIOD - 1) : 32'd0;

  // Backing store. It is preloaded hierarchically and never written through the bus.
  logic [31:0]   mem [MEM_WORDS];

  logic [31:0]   phase;
  logic          accept;
  logic [AW-1:0] idx_lo;
  logic [AW-1:0] idx_hi;
  logic [63:0]   pair;
  logic          vld_p [LATENCY];
  logic [63:0]   rd_p  [LATENCY];

  // The two byte-offset bits never select anything; a word pair is always returned.
  logic          unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, address[1:0]};

  // Wrap the word address into the array and align it down to an even word.
  function automatic logic [AW-1:0] pair_base(input logic [31:0] addr);
    logic [31:0] word;
    word = {2'b00, addr[31:2]} % 32'(MEM_WORDS);
    return AW'(word) & ~AW'(1);
  endfunction

  // Stall phase counter. It cycles 0..STALL_PERIOD-1 from reset release and
  // stays at 0 when stalls are disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= '0;
    else if (phase == SP_LAST)
      phase <= '0;
    else
      phase <= phase + 32'd1;
  end

  assign stall = (STALL_PERIOD > 0) && (phase == SP_LAST);

  // Acceptance and memory sampling. The upper word wraps to index 0 at the array end.
  always_comb begin
    accept = read && !stall;
    idx_lo = pair_base(address);
    idx_hi = (idx_lo == LAST_IDX) ? '0 : idx_lo + AW'(1);
    pair   = {mem[idx_hi], mem[idx_lo]};
  end

  // Response pipeline. Data moves only behind a valid entry, so the output
  // holds its last response across bubbles and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        rd_p[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++)
        vld_p[i] <= 1'b0;
    end else begin
      // ---- stage 0: accepted request enters with its sampled pair ----
      vld_p[0] <= accept;
      if (accept)
        rd_p[0] <= pair;
      // ---- stages 1..LATENCY-1: shift toward the output ----
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1])
          rd_p[i] <= rd_p[i-1];
      end
    end
  end

  assign valid  = vld_p[LATENCY-1];
  assign rddata = rd_p[LATENCY-1];

endmodule

// File: tb/tb_ibus_mem_model.sv
// Bench for ibus_mem_model: three instances with different latency, stall
// period and depth, driven by shared stimulus. Each instance is compared
// against a queue-based reference model of the bus behaviour.
module tb_ibus_mem_model;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        read    = 1'b0;
  logic        flush   = 1'b0;
  logic [31:0] address = '0;

  logic        stall_w  [3];
  logic        valid_w  [3];
  logic [63:0] rddata_w [3];

  logic [31:0] shadow [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected instruction pair for a byte address in an array of mw words.
  function automatic logic [63:0] fetch_pair(input int mw, input logic [31:0] a);
    int i;
    int j;
    i = int'({2'b00, a[31:2]}) % mw;
    i = i - (i % 2);
    j = (i + 1) % mw;
    return {shadow[j], shadow[i]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : (g == 2) ? 2 : 1;
    localparam int SP  = (g == 1) ? 4 : 0;
    localparam int MW  = (g == 1) ? 40 : 64;

    ibus_mem_model #(
      .MEM_WORDS   (MW),
      .LATENCY     (LAT),
      .STALL_PERIOD(SP)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .read   (read),
      .address(address),
      .flush  (flush),
      .stall  (stall_w[g]),
      .valid  (valid_w[g]),
      .rddata (rddata_w[g])
    );

    rsp_t        q[$];
    int          cyc       = 0;
    logic        exp_vld   = 1'b0;
    logic        exp_stall = 1'b0;
    logic [63:0] last      = '0;

    // Reference model: cyc is the index of the cycle that just ended at this edge.
    always @(posedge clk or negedge rst_n) begin
      bit   st;
      rsp_t r;
      if (!rst_n) begin
        q.delete();
        cyc       = 0;
        exp_vld   = 1'b0;
        exp_stall = 1'b0;
        last      = '0;
      end else begin
        st = (SP != 0) && (cyc % SP == SP - 1);
        if (flush) begin
          q.delete();
        end else if (read && !st) begin
          r.due  = cyc + LAT;
          r.data = fetch_pair(MW, address);
          q.push_back(r);
        end
        cyc++;
        exp_stall = (SP != 0) && (cyc % SP == SP - 1);
        exp_vld   = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
          r       = q.pop_front();
          exp_vld = 1'b1;
          last    = r.data;
        end
      end
    end

    // Compare every output mid-cycle against the model.
    always @(negedge clk) begin
      chk($sformatf("stall[%0d]", g),  {63'd0, stall_w[g]}, {63'd0, exp_stall});
      chk($sformatf("valid[%0d]", g),  {63'd0, valid_w[g]}, {63'd0, exp_vld});
      chk($sformatf("rddata[%0d]", g), rddata_w[g], last);
    end
  end

  task automatic step(input logic rd, input logic [31:0] a, input logic fl);
    @(posedge clk);
    #1;
    read    = rd;
    address = a;
    flush   = fl;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = $urandom;
    shadow[0] = 32'h11;
    shadow[1] = 32'h22;
    shadow[2] = 32'h33;
    shadow[3] = 32'h44;
    for (int i = 0; i < 64; i++) begin
      g_dut[0].u_dut.mem[i] = shadow[i];
      g_dut[2].u_dut.mem[i] = shadow[i];
    end
    for (int i = 0; i < 40; i++) g_dut[1].u_dut.mem[i] = shadow[i];

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid",  {63'd0, valid_w[0]}, 64'd0);
    chk("reset rddata", rddata_w[1], 64'd0);
    chk("reset stall",  {63'd0, stall_w[1]}, 64'd0);

    // cycle 0: first request after reset release
    rst_n = 1'b1; read = 1'b1; address = 32'h0;
    step(1'b1, 32'h8, 1'b0);  // cycle 1
    chk("basic0 valid", {63'd0, valid_w[0]}, 64'd1);
    chk("basic0 data",  rddata_w[0], 64'h00000022_00000011);
    step(1'b1, 32'h4, 1'b0);  // cycle 2
    chk("basic1 data",  rddata_w[0], 64'h00000044_00000033);
    step(1'b0, 32'h0, 1'b0);  // cycle 3
    chk("align data",   rddata_w[0], 64'h00000022_00000011);
    chk("stall c3",     {63'd0, stall_w[1]}, 64'd1);
    step(1'b1, 32'h0, 1'b0);  // cycle 4
    chk("stall c4",     {63'd0, stall_w[1]}, 64'd0);
    step(1'b1, 32'h8, 1'b0);  // cycle 5
    step(1'b1, 32'h10, 1'b0); // cycle 6
    chk("lat3 early",   {63'd0, valid_w[1]}, 64'd0);
    step(1'b0, 32'h0, 1'b0);  // cycle 7
    chk("lat3 r0",      rddata_w[1], 64'h00000022_00000011);
    chk("lat3 v0",      {63'd0, valid_w[1]}, 64'd1);
    step(1'b0, 32'h0, 1'b0);  // cycle 8
    chk("lat3 r1",      rddata_w[1], 64'h00000044_00000033);
    step(1'b0, 32'h0, 1'b0);  // cycle 9
    chk("lat3 r2",      rddata_w[1], {shadow[5], shadow[4]});
    step(1'b0, 32'h0, 1'b0);  // cycle 10
    chk("lat3 end",     {63'd0, valid_w[1]}, 64'd0);
    step(1'b0, 32'h0, 1'b0);  // cycle 11
    step(1'b1, 32'h0, 1'b0);  // cycle 12
    step(1'b1, 32'h8, 1'b1);  // cycle 13: flush with a request
    step(1'b1, 32'h10, 1'b0); // cycle 14
    chk("flush v14",    {63'd0, valid_w[2]}, 64'd0);
    step(1'b0, 32'h0, 1'b0);  // cycle 15
    chk("flush v15",    {63'd0, valid_w[2]}, 64'd0);
    step(1'b0, 32'h0, 1'b0);  // cycle 16
    chk("flush v16",    {63'd0, valid_w[2]}, 64'd1);
    chk("flush r16",    rddata_w[2], {shadow[5], shadow[4]});

    // Random traffic across the whole address space, with occasional flushes.
    repeat (300)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0);

    // Reset with responses still in flight.
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    step(1'b1, 32'h10, 1'b0);
    #1;
    rst_n = 1'b0;
    read  = 1'b0;
    #1;
    chk("rst async v0", {63'd0, valid_w[0]}, 64'd0);
    chk("rst async v1", {63'd0, valid_w[1]}, 64'd0);
    chk("rst async v2", {63'd0, valid_w[2]}, 64'd0);
    chk("rst async r2", rddata_w[2], 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("reread valid", {63'd0, valid_w[0]}, 64'd1);
    chk("reread data",  rddata_w[0], 64'h00000022_00000011);
    step(1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
